// File: rtl/uart_sample_rx.sv
// UART receiver that packs SAMPLE_BYTES characters (first received in the MSBs) into one
// filter sample, delivered over valid/ready with framing, parity, overrun and timeout handling.
module uart_sample_rx #(
   parameter int CLK_DIV      = 868,
   parameter int DATA_BITS    = 8,
   parameter int SAMPLE_BYTES = 2,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                rx_data,
   output logic [SAMPLE_BYTES*DATA_BITS-1:0]   sample_data,
   output logic                                sample_valid,
   input  logic                                sample_ready,
   output logic                                frame_err,
   output logic                                parity_err,
   output logic                                overrun,
   output logic                                busy
);

   localparam int W      = SAMPLE_BYTES * DATA_BITS;
   localparam int CW     = $clog2(CLK_DIV);
   localparam int BW     = $clog2(DATA_BITS);
   localparam int NW     = $clog2(SAMPLE_BYTES) + 1;
   localparam int TO_CYC = TIMEOUT_BITS * CLK_DIV;
   localparam int TW     = $clog2(TO_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           sync_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 drop_q, drop_d;
   logic [NW-1:0]        byte_q, byte_d;
   logic [W-1:0]         asm_q, asm_d, asm_next;
   logic [TW-1:0]        to_q, to_d;
   logic [W-1:0]         data_q;
   logic                 valid_q, fe_q, pe_q, ov_q, busy_q;
   logic                 fe_d, pe_d, complete;
   logic                 rx_s, tick, tick_half;

   assign rx_s      = sync_q[1];
   assign tick      = (cnt_q == CW'(CLK_DIV - 1));
   assign tick_half = (cnt_q == CW'(CLK_DIV / 2 - 1));
   // Older bytes move up; the newest character lands in the low bits.
   assign asm_next  = W'({asm_q, shift_q});

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      drop_d   = drop_q;
      byte_d   = byte_q;
      asm_d    = asm_q;
      to_d     = '0;
      fe_d     = 1'b0;
      pe_d     = 1'b0;
      complete = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (byte_q != '0) begin
               if (to_q == TW'(TO_CYC - 1)) byte_d = '0;
               else                         to_d   = to_q + TW'(1);
            end
            if (!rx_s) begin
               state_d = S_START;
               drop_d  = 1'b0;
            end
         end
         S_START: begin
            if (tick_half) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         S_PAR: begin
            if (tick) begin
               cnt_d   = '0;
               state_d = S_STOP;
               // Char still walks through its stop bits so the line stays in step.
               if ((^shift_q ^ rx_s) != (PARITY == 2)) begin
                  pe_d   = 1'b1;
                  drop_d = 1'b1;
                  byte_d = '0;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               cnt_d = '0;
               if (!rx_s) begin
                  fe_d    = 1'b1;
                  byte_d  = '0;
                  state_d = S_BREAK;
               end else if (bit_q != BW'(STOP_BITS - 1)) begin
                  bit_d = bit_q + BW'(1);
               end else begin
                  state_d = S_IDLE;
                  if (!drop_q) begin
                     asm_d = asm_next;
                     if (byte_q == NW'(SAMPLE_BYTES - 1)) begin
                        byte_d   = '0;
                        complete = 1'b1;
                     end else begin
                        byte_d = byte_q + NW'(1);
                     end
                  end
               end
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= 2'b11;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         drop_q  <= 1'b0;
         byte_q  <= '0;
         asm_q   <= '0;
         to_q    <= '0;
      end else begin
         sync_q  <= {sync_q[0], rx_data};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         drop_q  <= drop_d;
         byte_q  <= byte_d;
         asm_q   <= asm_d;
         to_q    <= to_d;
      end
   end

   // A completion while the consumer is stalled is dropped and reported as overrun.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         pe_q    <= 1'b0;
         ov_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         fe_q   <= fe_d;
         pe_q   <= pe_d;
         ov_q   <= complete && valid_q && !sample_ready;
         busy_q <= (state_d != S_IDLE);
         if (complete && !(valid_q && !sample_ready)) begin
            valid_q <= 1'b1;
            data_q  <= asm_next;
         end else if (sample_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign sample_data  = data_q;
   assign sample_valid = valid_q;
   assign frame_err    = fe_q;
   assign parity_err   = pe_q;
   assign overrun      = ov_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_uart_sample_rx.sv
// Directed bench for uart_sample_rx at CLK_DIV=16: one no-parity instance and one even-parity instance.
module tb_uart_sample_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1;
   logic [15:0] d0, d1;
   logic        v0, fe0, pe0, ov0, b0;
   logic        v1, fe1, pe1, ov1, b1;

   always #5 clk = ~clk;

   uart_sample_rx #(.CLK_DIV(16)) u0 (
      .clk(clk), .reset(reset), .rx_data(rx0), .sample_data(d0), .sample_valid(v0),
      .sample_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(b0));

   uart_sample_rx #(.CLK_DIV(16), .PARITY(1)) u1 (
      .clk(clk), .reset(reset), .rx_data(rx1), .sample_data(d1), .sample_valid(v1),
      .sample_ready(1'b1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(b1));

   int cmp = 0, err = 0;
   int cyc = 0, rise0 = 0, t_start = 0;
   int nv0 = 0, nfe0 = 0, npe0 = 0, nov0 = 0, nbusy0 = 0, nv1 = 0, npe1 = 0, nfe1 = 0;
   logic        pv0 = 1'b0;
   logic [15:0] last0 = '0, last1 = '0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      pv0 <= v0;
      if (v0) begin nv0 <= nv0 + 1; last0 <= d0; end
      if (v0 && !pv0) rise0 <= cyc;
      if (fe0) nfe0 <= nfe0 + 1;
      if (pe0) npe0 <= npe0 + 1;
      if (ov0) nov0 <= nov0 + 1;
      if (b0)  nbusy0 <= nbusy0 + 1;
      if (v1) begin nv1 <= nv1 + 1; last1 <= d1; end
      if (pe1) npe1 <= npe1 + 1;
      if (fe1) nfe1 <= nfe1 + 1;
   end

   task automatic bit0(input logic v);
      rx0 = v;
      repeat (16) @(negedge clk);
   endtask

   task automatic send0(input logic [7:0] b, input logic stop_ok);
      @(negedge clk);
      t_start = cyc;
      bit0(1'b0);
      for (int i = 0; i < 8; i++) bit0(b[i]);
      bit0(stop_ok);
      rx0 = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send1(input logic [7:0] b, input logic pbit);
      @(negedge clk);
      rx1 = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin rx1 = b[i]; repeat (16) @(negedge clk); end
      rx1 = pbit;
      repeat (16) @(negedge clk);
      rx1 = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset;
      int s;
      #1;
      cmp++; if ({v0, fe0, pe0, ov0, b0, d0} !== 21'd0) begin err++;
         $display("FAIL reset_init: got %h expected 0", {v0, fe0, pe0, ov0, b0, d0}); end
      @(negedge clk); reset = 1'b1;
      repeat (4) @(negedge clk);
      rdy0 = 1'b0;
      send0(8'h12, 1'b1); send0(8'h34, 1'b1);
      cmp++; if (v0 !== 1'b1 || d0 !== 16'h1234) begin err++;
         $display("FAIL reset_pending: got v=%b d=%h expected v=1 d=1234", v0, d0); end
      fork
         send0(8'h5A, 1'b1);
         begin
            repeat (60) @(negedge clk);
            cmp++; if (b0 !== 1'b1) begin err++;
               $display("FAIL reset_busy_pre: got %b expected 1", b0); end
            reset = 1'b0;
            #1;
            cmp++; if ({v0, fe0, pe0, ov0, b0, d0} !== 21'd0) begin err++;
               $display("FAIL reset_async: got %h expected 0", {v0, fe0, pe0, ov0, b0, d0}); end
         end
      join
      @(negedge clk); reset = 1'b1; rdy0 = 1'b1;
      repeat (4) @(negedge clk);
      s = nv0;
      send0(8'h12, 1'b1); send0(8'h34, 1'b1);
      cmp++; if (nv0 - s !== 1 || last0 !== 16'h1234) begin err++;
         $display("FAIL reset_after: got n=%0d d=%h expected n=1 d=1234", nv0 - s, last0); end
   endtask

   task automatic test_basic;
      int s, sf, sp, so;
      s = nv0; sf = nfe0; sp = npe0; so = nov0;
      send0(8'hAB, 1'b1); send0(8'hCD, 1'b1);
      cmp++; if (last0 !== 16'hABCD) begin err++;
         $display("FAIL basic_data: got %h expected abcd", last0); end
      cmp++; if (nv0 - s !== 1) begin err++;
         $display("FAIL basic_valid_width: got %0d cycles expected 1", nv0 - s); end
      // 2nd stop mid is 152 clks after its start edge, plus sync and output register.
      cmp++; if (rise0 - t_start < 150 || rise0 - t_start > 160) begin err++;
         $display("FAIL basic_latency: got %0d expected 150..160", rise0 - t_start); end
      cmp++; if (nfe0 != sf || npe0 != sp || nov0 != so) begin err++;
         $display("FAIL basic_flags: got fe=%0d pe=%0d ov=%0d expected 0", nfe0 - sf, npe0 - sp, nov0 - so); end
   endtask

   task automatic test_glitch;
      int s, sf, sb;
      s = nv0; sf = nfe0; sb = nbusy0;
      @(negedge clk); rx0 = 1'b0;
      repeat (4) @(negedge clk); rx0 = 1'b1;
      repeat (10) @(negedge clk);
      cmp++; if (b0 !== 1'b0 || nbusy0 == sb) begin err++;
         $display("FAIL glitch_busy: got busy=%b seen=%0d expected busy=0 seen>0", b0, nbusy0 - sb); end
      cmp++; if (nv0 != s || nfe0 != sf) begin err++;
         $display("FAIL glitch_flags: got v=%0d fe=%0d expected 0", nv0 - s, nfe0 - sf); end
   endtask

   task automatic test_frame;
      int s, sf;
      s = nv0; sf = nfe0;
      send0(8'h11, 1'b1); send0(8'h22, 1'b0);
      repeat (4) @(negedge clk);
      cmp++; if (nfe0 - sf !== 1 || nv0 != s) begin err++;
         $display("FAIL frame_err: got fe=%0d v=%0d expected fe=1 v=0", nfe0 - sf, nv0 - s); end
      send0(8'h12, 1'b1); send0(8'h34, 1'b1);
      cmp++; if (nv0 - s !== 1 || last0 !== 16'h1234) begin err++;
         $display("FAIL frame_recover: got n=%0d d=%h expected n=1 d=1234", nv0 - s, last0); end
   endtask

   task automatic test_parity;
      int s, sp;
      s = nv1; sp = npe1;
      send1(8'h01, 1'b0);
      cmp++; if (npe1 - sp !== 1 || nv1 != s) begin err++;
         $display("FAIL parity_bad: got pe=%0d v=%0d expected pe=1 v=0", npe1 - sp, nv1 - s); end
      send1(8'h01, 1'b1); send1(8'h02, 1'b1);
      cmp++; if (nv1 - s !== 1 || last1 !== 16'h0102 || npe1 - sp !== 1 || nfe1 != 0) begin err++;
         $display("FAIL parity_good: got n=%0d d=%h pe=%0d expected n=1 d=0102 pe=1", nv1 - s, last1, npe1 - sp); end
   endtask

   task automatic test_overrun_timeout;
      int s, so;
      rdy0 = 1'b0; so = nov0;
      send0(8'h01, 1'b1); send0(8'h02, 1'b1);
      send0(8'h03, 1'b1); send0(8'h04, 1'b1);
      cmp++; if (nov0 - so !== 1) begin err++;
         $display("FAIL overrun_pulse: got %0d expected 1", nov0 - so); end
      cmp++; if (v0 !== 1'b1 || d0 !== 16'h0102) begin err++;
         $display("FAIL overrun_hold: got v=%b d=%h expected v=1 d=0102", v0, d0); end
      rdy0 = 1'b1;
      @(negedge clk);
      cmp++; if (v0 !== 1'b0) begin err++;
         $display("FAIL overrun_pop: got %b expected 0", v0); end
      s = nv0;
      send0(8'hAA, 1'b1);
      repeat (40 * 16) @(negedge clk);
      send0(8'h56, 1'b1); send0(8'h78, 1'b1);
      cmp++; if (nv0 - s !== 1 || last0 !== 16'h5678) begin err++;
         $display("FAIL timeout: got n=%0d d=%h expected n=1 d=5678", nv0 - s, last0); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_glitch;
      test_frame;
      test_parity;
      test_overrun_timeout;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end

endmodule
